// File: rtl/fphub_align_pkg.sv
// Shared types and helpers for the FPHUB significand alignment sequencer.
package fphub_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

  // Magnitude of the signed exponent difference, clamped to the significand width.
  // Beyond m every significand bit is shifted out anyway, so larger distances are pointless.
  function automatic int sat_shamt(input int dif, input int m);
    int mag;
    mag = (dif < 0) ? -dif : dif;
    return (mag > m) ? m : mag;
  endfunction

endpackage

// File: rtl/align_shift_sequencer_expdiff.sv
// Exponent comparator: signed difference plus greater/equal flags for the swap decision.
module Exponent_difference #(
  parameter int E = 8
) (
  input  logic [E-1:0]      Ex,
  input  logic [E-1:0]      Ey,
  output logic signed [E:0] dif,
  output logic              X_greater_than_Y,
  output logic              Ex_equal_Ey
);

  // One extra bit keeps the difference of two unsigned exponents exact as a signed value.
  assign dif              = $signed({1'b0, Ex}) - $signed({1'b0, Ey});
  assign X_greater_than_Y = (Ex > Ey);
  assign Ex_equal_Ey      = (Ex == Ey);

endmodule

// File: rtl/align_shift_sequencer.sv
// Multi-cycle alignment controller in front of the FPHUB adder significand path.
// Swaps operands so the larger exponent is on the big side, then right-shifts the
// smaller significand by |Ex-Ey| (saturated to M) at most STEP bits per cycle.
// Optional feature macro: ALIGN_STICKY_EN builds the sticky accumulator; without it
// sticky is tied to 0.
import fphub_align_pkg::*;

module align_shift_sequencer #(
  parameter int E    = 8,
  parameter int M    = 24,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         Sx,
  input  logic         Sy,
  input  logic [E-1:0] Ex,
  input  logic [E-1:0] Ey,
  input  logic [M-1:0] Mx,
  input  logic [M-1:0] My,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         S_big,
  output logic         S_small,
  output logic [E-1:0] E_big,
  output logic [M-1:0] M_big,
  output logic [M-1:0] M_small,
  output logic         swapped,
  output logic         exp_eq,
  output logic         sticky
);

  localparam int SW = $clog2(M + 1);

  align_state_t      state;
  align_state_t      state_next;
  logic [SW-1:0]     rem;
  logic [SW-1:0]     shamt_in;
  logic [SW-1:0]     step;
  logic [M-1:0]      out_mask;
  logic signed [E:0] dif;
  logic              x_gt_y;
  logic              ex_eq_ey;
  logic              accept;

  Exponent_difference #(.E(E)) u_expdiff (
    .Ex               (Ex),
    .Ey               (Ey),
    .dif              (dif),
    .X_greater_than_Y (x_gt_y),
    .Ex_equal_Ey      (ex_eq_ey)
  );

  assign shamt_in  = SW'(sat_shamt(int'(dif), M));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);

  // Per-cycle shift distance and the mask selecting the bits it will push out.
  always_comb begin
    step     = (rem > SW'(STEP)) ? SW'(STEP) : rem;
    out_mask = ~({M{1'b1}} << step);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: zero-distance pairs skip SHIFT entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (shamt_in != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture with swap on accept, then stepwise right shift of the small side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_big   <= 1'b0;
      S_small <= 1'b0;
      E_big   <= '0;
      M_big   <= '0;
      M_small <= '0;
      swapped <= 1'b0;
      exp_eq  <= 1'b0;
      rem     <= '0;
    end else if (accept) begin
      swapped <= ~x_gt_y & ~ex_eq_ey;
      exp_eq  <= ex_eq_ey;
      rem     <= shamt_in;
      if (x_gt_y || ex_eq_ey) begin
        S_big   <= Sx;
        S_small <= Sy;
        E_big   <= Ex;
        M_big   <= Mx;
        M_small <= My;
      end else begin
        S_big   <= Sy;
        S_small <= Sx;
        E_big   <= Ey;
        M_big   <= My;
        M_small <= Mx;
      end
    end else if (state == SHIFT) begin
      M_small <= M_small >> step;
      rem     <= rem - step;
    end
  end

`ifdef ALIGN_STICKY_EN
  // Sticky accumulates every bit shifted off the bottom of the small significand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sticky <= 1'b0;
    else if (accept)         sticky <= 1'b0;
    else if (state == SHIFT) sticky <= sticky | (|(M_small & out_mask));
  end
`else
  assign sticky = 1'b0;
  logic unused_mask;
  assign unused_mask = ^out_mask;
`endif

endmodule

// File: tb/tb_align_shift_sequencer.sv
// Directed self-checking bench for align_shift_sequencer (E=8, M=24, STEP=4).
// Sticky expectations follow ALIGN_STICKY_EN.
module tb_align_shift_sequencer;

  localparam int E = 8;
  localparam int M = 24;
`ifdef ALIGN_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         Sx = 1'b0, Sy = 1'b0;
  logic [E-1:0] Ex = '0, Ey = '0;
  logic [M-1:0] Mx = '0, My = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         S_big, S_small;
  logic [E-1:0] E_big;
  logic [M-1:0] M_big, M_small;
  logic         swapped, exp_eq, sticky;

  int check_count = 0;
  int pass_count  = 0;
  int edges;
  logic [M-1:0] held_small;

  align_shift_sequencer #(.E(E), .M(M), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
    .out_valid(out_valid), .out_ready(out_ready),
    .S_big(S_big), .S_small(S_small), .E_big(E_big), .M_big(M_big),
    .M_small(M_small), .swapped(swapped), .exp_eq(exp_eq), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one operand pair and let it be taken at the next rising edge.
  task automatic apply_stimulus(input logic sx, input logic sy, input logic [E-1:0] ex,
                                input logic [E-1:0] ey, input logic [M-1:0] mx,
                                input logic [M-1:0] my);
    Sx = sx; Sy = sy; Ex = ex; Ey = ey; Mx = mx; My = my;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge (counted as 1) until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_M_small", M_small, 0);
    check_output("rst_E_big", E_big, 0);
    check_output("rst_sticky", sticky, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Case 1: shift by 3
    check_output("c1_in_ready", in_ready, 1);
    apply_stimulus(0, 0, 8'd130, 8'd127, 24'h800000, 24'hC00000);
    wait_done(edges);
    check_output("c1_latency", edges, 2);
    check_output("c1_E_big", E_big, 130);
    check_output("c1_M_big", M_big, 24'h800000);
    check_output("c1_M_small", M_small, 24'h180000);
    check_output("c1_swapped", swapped, 0);
    check_output("c1_sticky", sticky, 0);
    handshake();
    check_output("c1_back_idle", in_ready, 1);

    // Case 2: swap, shifts 4,4,2
    apply_stimulus(1, 0, 8'd100, 8'd110, 24'hFFFFFF, 24'h800000);
    wait_done(edges);
    check_output("c2_latency", edges, 4);
    check_output("c2_swapped", swapped, 1);
    check_output("c2_E_big", E_big, 110);
    check_output("c2_M_big", M_big, 24'h800000);
    check_output("c2_M_small", M_small, 24'h003FFF);
    check_output("c2_S_big", S_big, 0);
    check_output("c2_S_small", S_small, 1);
    check_output("c2_sticky", sticky, STICKY_ON);
    handshake();

    // Case 3: equal exponents
    apply_stimulus(0, 1, 8'd127, 8'd127, 24'hA00000, 24'h900000);
    wait_done(edges);
    check_output("c3_latency", edges, 1);
    check_output("c3_exp_eq", exp_eq, 1);
    check_output("c3_swapped", swapped, 0);
    check_output("c3_M_small", M_small, 24'h900000);
    check_output("c3_sticky", sticky, 0);
    handshake();

    // Case 4: saturated shift
    apply_stimulus(0, 0, 8'd200, 8'd10, 24'h800000, 24'h000001);
    wait_done(edges);
    check_output("c4_latency", edges, 7);
    check_output("c4_E_big", E_big, 200);
    check_output("c4_M_small", M_small, 0);
    check_output("c4_exp_eq", exp_eq, 0);
    check_output("c4_sticky", sticky, STICKY_ON);
    handshake();

    // Case 5: back-pressure in DONE, new input ignored
    apply_stimulus(0, 0, 8'd130, 8'd127, 24'h800000, 24'hC00000);
    wait_done(edges);
    held_small = M_small;
    check_output("c5_small_first", held_small, 24'h180000);
    Ex = 8'd50; Ey = 8'd60; Mx = 24'h123456; My = 24'h654321;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("c5_hold_valid", out_valid, 1);
      check_output("c5_hold_in_ready", in_ready, 0);
      check_output("c5_hold_small", M_small, 24'h180000);
      check_output("c5_hold_E_big", E_big, 130);
    end
    in_valid = 1'b0;
    handshake();
    check_output("c5_idle_valid", out_valid, 0);
    check_output("c5_idle_ready", in_ready, 1);

    // Case 6: reset in the second SHIFT cycle of case 2
    apply_stimulus(1, 0, 8'd100, 8'd110, 24'hFFFFFF, 24'h800000);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_output("c6_rst_valid", out_valid, 0);
    check_output("c6_rst_ready", in_ready, 1);
    check_output("c6_rst_small", M_small, 0);
    check_output("c6_rst_E_big", E_big, 0);
    check_output("c6_rst_swapped", swapped, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(0, 0, 8'd130, 8'd127, 24'h800000, 24'hC00000);
    wait_done(edges);
    check_output("c6_after_latency", edges, 2);
    check_output("c6_after_small", M_small, 24'h180000);
    check_output("c6_after_E_big", E_big, 130);
    handshake();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
